// File: rtl/pixel_fetch_ctrl_pkg.sv
// Shared types for the Sobel pixel fetch path.
// Window-shift directions and the fetch controller state encoding.
package sobel_pkg;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        REQ,
        WAIT,
        PUSH,
        SHIFT,
        PRESENT,
        DONE
    } state_t;

    localparam logic [3:0] FILL_LAST = 4'd8;
    localparam logic [3:0] EDGE_LAST = 4'd2;

endpackage

// File: rtl/pixel_fetch_ctrl_scan_position_counter.sv
// Window center tracker for the serpentine frame scan.
// Reports the next move and whether the current window is the last one.
module scan_position_counter
    import sobel_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init,
    input  logic                       step,
    output logic [$clog2(IMG_H)-1:0]   row,
    output logic [$clog2(IMG_W)-1:0]   col,
    output dir_t                       move,
    output logic                       last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic go_right;
    logic at_end;

    // A one-column-wide scan is always at a row end, so it only moves down.
    assign at_end = go_right ? (col == CW'(IMG_W - 2))
                             : (col == CW'(1));

    assign move = at_end ? DIR_DOWN
                         : (go_right ? DIR_RIGHT : DIR_LEFT);

    assign last = at_end && (row == RW'(IMG_H - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row      <= RW'(1);
            col      <= CW'(1);
            go_right <= 1'b1;
        end else if (init) begin
            row      <= RW'(1);
            col      <= CW'(1);
            go_right <= 1'b1;
        end else if (step) begin
            unique case (move)
                DIR_RIGHT: col <= col + CW'(1);
                DIR_LEFT:  col <= col - CW'(1);
                DIR_DOWN: begin
                    row      <= row + RW'(1);
                    go_right <= !go_right;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Fetches 3x3 Sobel windows from pixel memory in a serpentine scan,
// loading the window buffer one pixel per read and one edge per shift.
module pixel_fetch_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              start_shift,
    output logic              start_read,
    output logic [1:0]        shift_direc,
    output logic [7:0]        data_r,
    output logic              win_valid,
    input  logic              win_ack,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t state;
    state_t state_nx;
    dir_t   mv_dir;

    logic [3:0]    k;
    logic [3:0]    k_src;
    logic [3:0]    kd;
    logic [3:0]    km;
    logic [3:0]    last_k;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    dir_t          move;
    logic          last;
    logic          pos_init;
    logic          pos_step;
    logic [31:0]   ra;
    logic [31:0]   ca;
    logic [31:0]   addr_full;

    assign pos_init = (state == IDLE) && start;
    assign pos_step = (state == PRESENT) && win_ack && !last;
    assign last_k   = (mv_dir == DIR_NONE) ? FILL_LAST : EDGE_LAST;

    scan_position_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .init (pos_init),
        .step (pos_step),
        .row  (row),
        .col  (col),
        .move (move),
        .last (last)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = REQ;
            REQ:     state_nx = WAIT;
            WAIT:    if (mem_rvalid) state_nx = PUSH;
            PUSH:    state_nx = (k == last_k) ? PRESENT : REQ;
            SHIFT:   state_nx = REQ;
            PRESENT: if (win_ack) state_nx = last ? DONE : SHIFT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_ren     = (state == REQ);
    assign start_read  = (state == PUSH);
    assign start_shift = (state == CLEAR) || (state == SHIFT);
    assign shift_direc = (state == SHIFT) ? mv_dir : DIR_NONE;
    assign win_valid   = (state == PRESENT);
    assign frame_done  = (state == DONE);
    assign busy        = (state != IDLE) && (state != DONE);

    // Fetch index for the read about to be issued; the center has already
    // moved by the time SHIFT runs, so edges are relative to the new center.
    always_comb begin
        k_src = (state == PUSH) ? (k + 4'd1) : 4'd0;
        kd    = k_src / 4'd3;
        km    = k_src % 4'd3;
        ra    = '0;
        ca    = '0;
        unique case (mv_dir)
            DIR_NONE: begin
                ra = 32'(row) - 32'd1 + 32'(kd);
                ca = 32'(col) - 32'd1 + 32'(km);
            end
            DIR_RIGHT: begin
                ra = 32'(row) - 32'd1 + 32'(k_src);
                ca = 32'(col) + 32'd1;
            end
            DIR_LEFT: begin
                ra = 32'(row) - 32'd1 + 32'(k_src);
                ca = 32'(col) - 32'd1;
            end
            DIR_DOWN: begin
                ra = 32'(row) + 32'd1;
                ca = 32'(col) - 32'd1 + 32'(k_src);
            end
            default: ;
        endcase
        addr_full = ra * 32'(IMG_W) + ca;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mv_dir   <= DIR_NONE;
            k        <= 4'd0;
            mem_addr <= '0;
            data_r   <= 8'd0;
        end else begin
            state <= state_nx;
            if (pos_init)
                mv_dir <= DIR_NONE;
            else if (pos_step)
                mv_dir <= move;
            if ((state == CLEAR) || (state == SHIFT))
                k <= 4'd0;
            else if (state == PUSH)
                k <= k + 4'd1;
            if (state_nx == REQ)
                mem_addr <= ADDR_W'(addr_full);
            if ((state == WAIT) && mem_rvalid)
                data_r <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Directed bench for pixel_fetch_ctrl: 4x4 frame scans with a memory
// model, reset mid-fetch, and a 3x5 frame on a second instance.
module tb_pixel_fetch_ctrl;

    logic clk;
    logic rst;

    logic       a_start, a_ren, a_rvalid, a_sshift, a_sread;
    logic       a_wv, a_ack, a_busy, a_fd;
    logic [3:0] a_addr;
    logic [7:0] a_rdata, a_data_r;
    logic [1:0] a_dir;

    logic       b_start, b_ren, b_rvalid, b_sshift, b_sread;
    logic       b_wv, b_ack, b_busy, b_fd;
    logic [3:0] b_addr;
    logic [7:0] b_rdata, b_data_r;
    logic [1:0] b_dir;

    int total, bad;

    pixel_fetch_ctrl #(.IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .start(a_start),
        .mem_ren(a_ren), .mem_addr(a_addr),
        .mem_rvalid(a_rvalid), .mem_rdata(a_rdata),
        .start_shift(a_sshift), .start_read(a_sread),
        .shift_direc(a_dir), .data_r(a_data_r),
        .win_valid(a_wv), .win_ack(a_ack),
        .busy(a_busy), .frame_done(a_fd)
    );

    pixel_fetch_ctrl #(.IMG_W(3), .IMG_H(5)) dut3 (
        .clk(clk), .rst(rst), .start(b_start),
        .mem_ren(b_ren), .mem_addr(b_addr),
        .mem_rvalid(b_rvalid), .mem_rdata(b_rdata),
        .start_shift(b_sshift), .start_read(b_sread),
        .shift_direc(b_dir), .data_r(b_data_r),
        .win_valid(b_wv), .win_ack(b_ack),
        .busy(b_busy), .frame_done(b_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- instance A monitor + memory model
    logic [31:0] a_addr_q[$];
    logic [31:0] a_data_q[$];
    logic [31:0] a_dir_q[$];
    int a_lat, a_cnt, a_hold, a_hold_cyc, a_hold_bad;
    int a_rv_n, a_sr_n, a_win_n, a_fd_n, a_overlap;
    bit a_pend, a_holding, a_wv_q;
    logic [3:0] a_paddr;

    initial begin
        a_rvalid = 0; a_rdata = 0; a_ack = 0; a_pend = 0; a_wv_q = 0;
        forever begin
            @(posedge clk); #1;
            a_rvalid = 0;
            if (a_pend) begin
                a_cnt--;
                if (a_cnt == 0) begin
                    a_rvalid = 1; a_rdata = {4'd0, a_paddr};
                    a_pend = 0; a_rv_n++;
                end
            end
            if (a_ren) begin
                a_pend = 1; a_cnt = a_lat; a_paddr = a_addr;
                a_addr_q.push_back(32'(a_addr));
            end
            if (a_sread) begin
                a_data_q.push_back(32'(a_data_r)); a_sr_n++;
            end
            if (a_sshift) a_dir_q.push_back(32'(a_dir));
            if (int'(a_ren) + int'(a_sread) + int'(a_sshift) > 1)
                a_overlap++;
            if (a_wv && !a_wv_q) a_win_n++;
            a_wv_q = a_wv;
            if (a_fd) a_fd_n++;
            if (a_hold > 0 && (a_wv || a_holding)) begin
                a_holding = 1; a_hold--; a_hold_cyc++;
                if (!a_wv || a_ren || a_sshift) a_hold_bad++;
                a_ack = 0;
            end else begin
                a_ack = a_wv;
            end
        end
    end

    task automatic clear_a();
        a_addr_q.delete(); a_data_q.delete(); a_dir_q.delete();
        a_rv_n = 0; a_sr_n = 0; a_win_n = 0; a_fd_n = 0; a_overlap = 0;
        a_hold = 0; a_hold_cyc = 0; a_hold_bad = 0; a_holding = 0;
    endtask

    task automatic pulse_a();
        @(negedge clk) a_start = 1;
        @(negedge clk) a_start = 0;
    endtask

    task automatic run_a(input int lat, input int hold);
        clear_a();
        a_lat = lat; a_hold = hold;
        pulse_a();
        for (int i = 0; i < 3000 && a_fd_n == 0; i++) @(negedge clk);
        chk("frame_end", a_fd_n, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        logic [31:0] ea [18];
        logic [31:0] ed [4];
        logic [31:0] g;
        ea = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 3, 7, 11, 13, 14, 15, 4, 8, 12};
        ed = '{0, 1, 3, 2};
        chk({tag, "_nreads"}, a_addr_q.size(), 18);
        chk({tag, "_nsread"}, a_data_q.size(), 18);
        for (int i = 0; i < 18; i++) begin
            g = (i < a_addr_q.size()) ? a_addr_q[i] : 32'hx;
            chk($sformatf("%s_addr%0d", tag, i), g, ea[i]);
            g = (i < a_data_q.size()) ? a_data_q[i] : 32'hx;
            chk($sformatf("%s_data%0d", tag, i), g, ea[i]);
        end
        chk({tag, "_nshift"}, a_dir_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            g = (i < a_dir_q.size()) ? a_dir_q[i] : 32'hx;
            chk($sformatf("%s_dir%0d", tag, i), g, ed[i]);
        end
        chk({tag, "_wins"}, a_win_n, 4);
        chk({tag, "_fdone"}, a_fd_n, 1);
        chk({tag, "_overlap"}, a_overlap, 0);
        chk({tag, "_busy"}, a_busy, 0);
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_ren"}, a_ren, 0);
        chk({tag, "_addr"}, a_addr, 0);
        chk({tag, "_sshift"}, a_sshift, 0);
        chk({tag, "_sread"}, a_sread, 0);
        chk({tag, "_dir"}, a_dir, 0);
        chk({tag, "_data"}, a_data_r, 0);
        chk({tag, "_wv"}, a_wv, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_fd"}, a_fd, 0);
    endtask

    // ---------------- instance B monitor + memory model
    int b_rd_n, b_dn_n, b_sh_n, b_win_n, b_fd_n, b_last_addr;
    bit b_pend, b_wv_q;
    logic [3:0] b_paddr;

    initial begin
        b_rvalid = 0; b_rdata = 0; b_ack = 0; b_pend = 0; b_wv_q = 0;
        forever begin
            @(posedge clk); #1;
            b_rvalid = b_pend;
            if (b_pend) b_rdata = {4'd0, b_paddr};
            b_pend = 0;
            if (b_ren) begin
                b_pend = 1; b_paddr = b_addr;
                b_rd_n++; b_last_addr = int'(b_addr);
            end
            if (b_sshift) begin
                b_sh_n++;
                if (b_dir == 2'b11) b_dn_n++;
            end
            if (b_wv && !b_wv_q) b_win_n++;
            b_wv_q = b_wv;
            if (b_fd) b_fd_n++;
            b_ack = b_wv;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst = 1; a_start = 0; b_start = 0;
        a_lat = 1; a_hold = 0;
        clear_a();
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("rst0");
        @(negedge clk) rst = 0;
        repeat (2) @(negedge clk);

        run_a(1, 0);
        check_frame("lat1");

        run_a(3, 10);
        check_frame("lat3");
        chk("hold_cycles", a_hold_cyc, 10);
        chk("hold_bad", a_hold_bad, 0);
        chk("rv_vs_sread", a_sr_n, a_rv_n);

        clear_a();
        a_lat = 3;
        pulse_a();
        for (int i = 0; i < 500 && a_addr_q.size() < 5; i++) @(negedge clk);
        chk("fifth_req", a_addr_q.size(), 5);
        @(posedge clk); #2;
        chk("in_wait_busy", a_busy, 1);
        rst = 1;
        #1;
        check_reset_a("rstw");
        @(posedge clk); #1;
        check_reset_a("rstw_edge");
        clear_a();
        @(negedge clk) rst = 0;
        repeat (6) @(negedge clk);
        chk("stale_rvalid_seen", a_rv_n, 1);
        chk("stale_sread", a_sr_n, 0);
        chk("stale_busy", a_busy, 0);

        run_a(1, 0);
        check_frame("restart");

        @(negedge clk) b_start = 1;
        @(negedge clk) b_start = 0;
        repeat (20) @(negedge clk);
        chk("b_busy_mid", b_busy, 1);
        @(negedge clk) b_start = 1;
        @(negedge clk) b_start = 0;
        for (int i = 0; i < 2000 && b_fd_n == 0; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        chk("b_fdone", b_fd_n, 1);
        chk("b_busy_end", b_busy, 0);
        chk("b_reads", b_rd_n, 15);
        chk("b_shifts", b_sh_n, 3);
        chk("b_down", b_dn_n, 2);
        chk("b_wins", b_win_n, 3);
        chk("b_last_addr", b_last_addr, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
